// File: rtl/mmio_console_if.sv
// Bundles the CPU load/store port and the TX byte stream of mmio_console.
// Ports: raddr/rdata/rd_hit (registered read), we/waddr/wdata (write),
//        tx_valid/tx_data/tx_ready (valid/ready byte stream to the sink).
interface mmio_console_if;
    logic [14:0] raddr;
    logic [15:0] rdata;
    logic        rd_hit;
    logic        we;
    logic [14:0] waddr;
    logic [15:0] wdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    // CPU memory stage plus byte sink
    modport master (
        output raddr, we, waddr, wdata, tx_ready,
        input  rdata, rd_hit, tx_valid, tx_data
    );

    // console responder
    modport slave (
        input  raddr, we, waddr, wdata, tx_ready,
        output rdata, rd_hit, tx_valid, tx_data
    );
endinterface

// File: rtl/mmio_console.sv
// Memory-mapped console: TXDATA stores feed a byte FIFO drained over valid/ready; loads return status/cycle counter.
// Latency: reads registered (1 cycle); pushed byte visible on tx_valid 1 cycle later.
// Backpressure: tx_ready low holds the head byte; a push into a full FIFO without a pop is dropped and sets sticky overflow.
// Ports: clk, rst_n (async active-low), bus (mmio_console_if.slave).
// Optional: define MMIO_CYCLE_CTR_EN to build the 32-bit cycle counter and hi shadow.
module mmio_console #(
    parameter logic [14:0] BASE_WADDR = 15'h7F80,
    parameter int          FIFO_DEPTH = 16,
    parameter int          FIFO_AW    = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mmio_console_if.slave  bus
);

    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(FIFO_DEPTH);

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_ovf;
    logic [15:0]        r_rdata;
    logic               r_rd_hit;

    logic [14:0] w_roff;
    logic [14:0] w_woff;
    logic        w_rd_in;
    logic        w_wr_in;
    logic        w_push_req;
    logic        w_clr;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic        w_reject;
    logic        w_tx_valid;
    logic [15:0] w_status;
    logic [15:0] w_rd_mux;
    logic [15:0] w_cyc_lo;
    logic [15:0] w_cyc_hi;
    logic        w_unused;

    // Offsets wrap for addresses below the base, so one unsigned compare covers both edges of the window.
    assign w_roff  = bus.raddr - BASE_WADDR;
    assign w_woff  = bus.waddr - BASE_WADDR;
    assign w_rd_in = (w_roff < 15'd8);
    assign w_wr_in = (w_woff < 15'd8);

    assign w_push_req = bus.we && w_wr_in && (w_woff[2:0] == 3'd0);
    assign w_clr      = bus.we && w_wr_in && (w_woff[2:0] == 3'd1) && bus.wdata[15];

    assign w_tx_valid = (r_count != '0);
    assign w_full     = (r_count == DEPTH_C);
    assign w_pop      = w_tx_valid && bus.tx_ready;
    // A pop frees the slot the push lands in, so a full FIFO still accepts when draining.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_reject   = w_push_req && !w_push;

    assign w_status = {r_ovf, 7'b0, 8'(16'(r_count))};

    assign w_unused = ^bus.wdata[14:8];

`ifdef MMIO_CYCLE_CTR_EN
    logic [31:0] r_cycle;
    logic [15:0] r_cyc_hi;

    // Reading CYCLE_LO snapshots the upper half so a following CYCLE_HI read is coherent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle  <= '0;
            r_cyc_hi <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_rd_in && (w_roff[2:0] == 3'd2))
                r_cyc_hi <= r_cycle[31:16];
        end
    end

    assign w_cyc_lo = r_cycle[15:0];
    assign w_cyc_hi = r_cyc_hi;
`else
    assign w_cyc_lo = '0;
    assign w_cyc_hi = '0;
`endif

    always_comb begin
        w_rd_mux = '0;
        if (w_rd_in) begin
            case (w_roff[2:0])
                3'd1:    w_rd_mux = w_status;
                3'd2:    w_rd_mux = w_cyc_lo;
                3'd3:    w_rd_mux = w_cyc_hi;
                default: w_rd_mux = '0;
            endcase
        end
    end

    // Read data reflects state before any same-cycle push/clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata  <= '0;
            r_rd_hit <= 1'b0;
        end else begin
            r_rdata  <= w_rd_mux;
            r_rd_hit <= w_rd_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A rejected push wins over a same-cycle clear.
            r_ovf <= (r_ovf && !w_clr) || w_reject;
        end
    end

    // Storage needs no reset; occupancy gates what is visible.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.wdata[7:0];
    end

    assign bus.rdata    = r_rdata;
    assign bus.rd_hit   = r_rd_hit;
    assign bus.tx_valid = w_tx_valid;
    // Forced to zero when empty so reset clears tx_data immediately.
    assign bus.tx_data  = w_tx_valid ? r_mem[r_rd_ptr] : 8'h00;

endmodule

// File: tb/tb_mmio_console.sv
module tb_mmio_console;

    localparam logic [14:0] BASE  = 15'h7F80;
    localparam int          DEPTH = 16;
    localparam logic [14:0] IDLE  = 15'h0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic chk_en = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    mmio_console_if bus();

    mmio_console #(.BASE_WADDR(BASE), .FIFO_DEPTH(DEPTH), .FIFO_AW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: queue of bytes, sticky flag, cycle count since reset.
    bit [7:0]  m_q[$];
    bit        m_ovf;
    bit [31:0] m_cyc;
    bit [15:0] m_shadow;
    bit        m_hit;
    bit [15:0] m_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0; m_cyc = '0; m_shadow = '0; m_hit = 1'b0; m_rdata = '0;
    endtask

    // Evaluated at the clock edge from the inputs presented during the cycle.
    task automatic model_step();
        int  roff, woff;
        bit  pop, push, rej, clr;
        roff = int'(bus.raddr) - int'(BASE);
        woff = int'(bus.waddr) - int'(BASE);
        pop  = (m_q.size() != 0) && bus.tx_ready;
        push = 1'b0; rej = 1'b0; clr = 1'b0;
        m_hit   = (roff >= 0) && (roff < 8);
        m_rdata = 16'h0000;
        if (m_hit) begin
            if (roff == 1) m_rdata = {m_ovf, 7'b0, 8'(m_q.size())};
`ifdef MMIO_CYCLE_CTR_EN
            if (roff == 2) begin m_rdata = m_cyc[15:0]; m_shadow = m_cyc[31:16]; end
            else if (roff == 3) m_rdata = m_shadow;
`endif
        end
        if (bus.we && woff == 0) begin
            if (m_q.size() < DEPTH || pop) push = 1'b1;
            else rej = 1'b1;
        end
        if (bus.we && woff == 1 && bus.wdata[15]) clr = 1'b1;
        if (pop)  void'(m_q.pop_front());
        if (push) m_q.push_back(bus.wdata[7:0]);
        m_ovf = (m_ovf && !clr) || rej;
        m_cyc = m_cyc + 32'd1;
    endtask

    task automatic do_cycle(input logic we, input logic [14:0] wa, input logic [15:0] wd,
                            input logic [14:0] ra, input logic rdy);
        bus.we = we; bus.waddr = wa; bus.wdata = wd; bus.raddr = ra; bus.tx_ready = rdy;
        @(posedge clk);
        if (rst_n) model_step(); else model_reset();
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        do_cycle(1'b0, IDLE, 16'h0000, IDLE, rdy);
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("cmp_rd_hit",   bus.rd_hit,   m_hit);
            chk("cmp_rdata",    bus.rdata,    m_rdata);
            chk("cmp_tx_valid", bus.tx_valid, m_q.size() != 0);
            chk("cmp_tx_data",  bus.tx_data,  (m_q.size() != 0) ? m_q[0] : 8'h00);
        end
    end

    initial begin
        logic [7:0] got[$];
        int guard;
        bus.we = 1'b0; bus.waddr = IDLE; bus.wdata = '0; bus.raddr = IDLE; bus.tx_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_rdata",    bus.rdata,    16'h0000);
        chk("reset_rd_hit",   bus.rd_hit,   1'b0);
        chk("reset_tx_valid", bus.tx_valid, 1'b0);
        chk("reset_tx_data",  bus.tx_data,  8'h00);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // STATUS after reset
        do_cycle(1'b0, IDLE, 16'h0, 15'h7F81, 1'b0);
        chk("status0_hit",   bus.rd_hit,   1'b1);
        chk("status0_rdata", bus.rdata,    16'h0000);
        chk("status0_txv",   bus.tx_valid, 1'b0);

        // single byte, sink ready: visible exactly one cycle
        do_cycle(1'b1, 15'h7F80, 16'h0141, IDLE, 1'b1);
        chk("one_txv",  bus.tx_valid, 1'b1);
        chk("one_txd",  bus.tx_data,  8'h41);
        idle(1'b1);
        chk("one_gone", bus.tx_valid, 1'b0);
        do_cycle(1'b0, IDLE, 16'h0, 15'h7F81, 1'b1);
        chk("one_status", bus.rdata, 16'h0000);

        // overflow: 17 stores with sink stalled
        for (int i = 0; i <= 16; i++) do_cycle(1'b1, 15'h7F80, 16'(i), IDLE, 1'b0);
        do_cycle(1'b0, IDLE, 16'h0, 15'h7F81, 1'b0);
        chk("ovf_status", bus.rdata, 16'h8010);
        do_cycle(1'b1, 15'h7F81, 16'h8000, IDLE, 1'b0);
        do_cycle(1'b0, IDLE, 16'h0, 15'h7F81, 1'b0);
        chk("clr_status", bus.rdata, 16'h0010);

        // drain and check order
        got.delete();
        for (int k = 0; k < 40 && got.size() < 16; k++) begin
            if (bus.tx_valid) got.push_back(bus.tx_data);
            idle(1'b1);
        end
        chk("drain_count", got.size(), 16);
        for (int i = 0; i < got.size(); i++) chk("drain_byte", got[i], 8'(i));
        idle(1'b0);

        // full FIFO, simultaneous pop and push
        for (int i = 0; i < 16; i++) do_cycle(1'b1, 15'h7F80, 16'(8'h20 + i), IDLE, 1'b0);
        do_cycle(1'b1, 15'h7F80, 16'h00AA, 15'h7F81, 1'b1);
        chk("full_pp_pre", bus.rdata, 16'h0010);
        do_cycle(1'b0, IDLE, 16'h0, 15'h7F81, 1'b0);
        chk("full_pp_post", bus.rdata, 16'h0010);
        repeat (20) idle(1'b1);

        // outside the window
        do_cycle(1'b1, 15'h7F88, 16'h0055, 15'h7F7F, 1'b0);
        chk("lo_out_hit",   bus.rd_hit, 1'b0);
        chk("lo_out_rdata", bus.rdata,  16'h0000);
        do_cycle(1'b1, 15'h7F7F, 16'h0055, 15'h7F88, 1'b0);
        chk("hi_out_hit",   bus.rd_hit, 1'b0);
        chk("hi_out_rdata", bus.rdata,  16'h0000);
        chk("out_no_push",  bus.tx_valid, 1'b0);

        // reset with bytes queued
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 15'h7F80, 16'(8'h61 + i), IDLE, 1'b0);
        chk("pre_rst_txv", bus.tx_valid, 1'b1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_txv", bus.tx_valid, 1'b0);
        chk("async_rst_txd", bus.tx_data,  8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        do_cycle(1'b0, IDLE, 16'h0, 15'h7F81, 1'b0);
        chk("post_rst_status", bus.rdata, 16'h0000);

        // cycle counter
`ifdef MMIO_CYCLE_CTR_EN
        guard = 0;
        while (m_cyc != 32'h0000FFFF && guard < 70000) begin idle(1'b0); guard++; end
        chk("cyc_reach", m_cyc, 32'h0000FFFF);
        do_cycle(1'b0, IDLE, 16'h0, 15'h7F82, 1'b0);
        chk("cyc_lo_hit", bus.rd_hit, 1'b1);
        chk("cyc_lo",     bus.rdata,  16'hFFFF);
        do_cycle(1'b0, IDLE, 16'h0, 15'h7F83, 1'b0);
        chk("cyc_hi_shadow", bus.rdata, 16'h0000);
        do_cycle(1'b0, IDLE, 16'h0, 15'h7F82, 1'b0);
        chk("cyc_lo2", bus.rdata, 16'h0001);
        do_cycle(1'b0, IDLE, 16'h0, 15'h7F83, 1'b0);
        chk("cyc_hi2", bus.rdata, 16'h0001);
`else
        guard = 0;
        do_cycle(1'b0, IDLE, 16'h0, 15'h7F82, 1'b0);
        chk("cyc_lo_hit", bus.rd_hit, 1'b1);
        chk("cyc_lo",     bus.rdata,  16'h0000);
        do_cycle(1'b0, IDLE, 16'h0, 15'h7F83, 1'b0);
        chk("cyc_hi_hit", bus.rd_hit, 1'b1);
        chk("cyc_hi",     bus.rdata,  16'h0000);
`endif

        // random traffic: stalled sink first, then mostly ready
        for (int ph = 0; ph < 2; ph++) begin
            for (int n = 0; n < 1500; n++) begin
                logic        we, rdy;
                logic [14:0] wa, ra;
                logic [15:0] wd;
                int          wo;
                we  = ($urandom_range(0, 99) < 60);
                wo  = ($urandom_range(0, 1) != 0) ? 1 : $urandom_range(0, 10);
                wo  = (wo == 1) ? 1 : ((wo < 6) ? 0 : wo - 3);
                wa  = 15'(int'(BASE) + wo - 1);
                ra  = 15'(int'(BASE) + int'($urandom_range(0, 9)) - 1);
                wd  = 16'($urandom);
                rdy = (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                do_cycle(we, wa, wd, ra, rdy);
            end
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_console.md
Name: mmio_console

Overview:
- Memory-mapped console responder on the CPU data port, the slave end of the memory-stage load/store interface.
- Decodes a small word-address window:
  - stores to TXDATA are queued in a byte FIFO and drained over a valid/ready byte stream;
  - loads return FIFO status and a free-running 32-bit cycle counter.
- Read timing matches the data-memory port (one-cycle registered read), so the top level muxes rdata on rd_hit.

Parameters:
- BASE_WADDR, 15'h7F80, word address of register 0; window is BASE_WADDR..BASE_WADDR+7.
- FIFO_DEPTH, 16, TX FIFO entries; power of two, 2..256.
- FIFO_AW, 4, log2(FIFO_DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- raddr  in  15  word read address (byte address [15:1]), sampled every cycle.
- rdata  out  16  registered read data, valid the cycle after raddr.
- rd_hit  out  1  registered; 1 when the previous-cycle raddr was inside the window.
- we  in  1  write enable.
- waddr  in  15  word write address.
- wdata  in  16  write data.
- tx_valid  out  1  FIFO head byte available.
- tx_data  out  8  FIFO head byte.
- tx_ready  in  1  sink accepts byte when tx_valid&&tx_ready.

Behaviour:
- Reset (async assert, sync release):
  - rdata=0, rd_hit=0, tx_valid=0, tx_data=0;
  - FIFO empty, overflow=0, cycle counter=0, hi shadow=0.
- Register map (offset = addr-BASE_WADDR):
  - 0 TXDATA: W pushes wdata[7:0]; R returns 0.
  - 1 STATUS: R = {overflow, 7'b0, count[7:0]} where count = FIFO occupancy (bit0 of a separate flag is not used).
  - 1 STATUS: W with wdata[15]=1 clears overflow; other bits ignored.
  - 2 CYCLE_LO: R returns counter[15:0] and latches counter[31:16] into the hi shadow.
  - 3 CYCLE_HI: R returns the hi shadow.
  - 4..7: R returns 0; W ignored.
- Outside the window: rd_hit=0, rdata=0, writes ignored.
- Read latency: exactly 1 cycle. A read and a write in the same cycle return pre-write state (count and overflow before the push or clear).
- Push accept rule: accepted iff count<FIFO_DEPTH, or a pop occurs in the same cycle.
  - A rejected push sets overflow (sticky).
  - An overflow clear and a rejected push in the same cycle leaves overflow=1.
- Pop: occurs when tx_valid&&tx_ready.
  - tx_valid = (count!=0).
  - tx_data is the head entry and is held stable while tx_valid&&!tx_ready.
  - A byte pushed into an empty FIFO appears on tx_valid the next cycle (1-cycle fall-through).
  - Simultaneous push and pop leave count unchanged.
- Pointers: wrap modulo FIFO_DEPTH; count is FIFO_AW+1 bits wide.
- Cycle counter:
  - increments by 1 every cycle after reset and wraps 0xFFFFFFFF->0;
  - a CYCLE_LO read returns the value sampled at the raddr cycle.
- Reset mid-transfer: FIFO contents are discarded and tx_valid drops asynchronously.

Optional Feature:
- Macro: MMIO_CYCLE_CTR_EN.
- Defined: counter and hi shadow are implemented as above.
- Undefined: no counter or shadow flops; reads of CYCLE_LO and CYCLE_HI return 0, and rd_hit still asserts for those offsets.

Test Plan:
- Reset, then read STATUS (raddr=7F81) -> next cycle rd_hit=1, rdata=16'h0000, tx_valid=0.
- Store 16'h0141 to 7F80 with tx_ready=1 -> tx_valid=1 with tx_data=8'h41 for exactly one cycle, then STATUS reads 0.
- tx_ready=0, 17 stores of 0x00..0x10 -> STATUS=16'h8010, and the drained bytes are 0x00..0x0F in order (0x10 dropped). Then write 16'h8000 to 7F81 -> STATUS=16'h0010.
- FIFO full with tx_ready=1 and a push in the same cycle -> push accepted, count stays 16, overflow stays 0.
- Read 7F82 at cycle N, then 7F83 -> rdata equals counter[15:0] at N, and the hi value sampled at N is unaffected by a later low-half carry. Without MMIO_CYCLE_CTR_EN both reads return 0 with rd_hit=1.
- Read 7F7F and 7F88 -> rd_hit=0, rdata=0. Assert rst_n=0 with 3 bytes queued -> tx_valid=0 immediately, and STATUS reads 0 after release.
